conv_loop_sequencer: RTL and testbench

- Generates the convolution loop-iterator tuple (m, r, c, n, i, j) that drives the address-generation controller directly downstream.
- Walks the full nested loop over output channel, output row, output column, input-channel group, kernel row and kernel column.
- Flags the first and last MAC of each output pixel so the downstream accumulator and output-buffer write can be timed.
- Started by a single pulse; throttled by a downstream stall; reports completion with a one-cycle done pulse.

---
 rtl/conv_loop_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_conv_loop_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_loop_sequencer.sv
// Convolution loop-iterator sequencer: walks (m, r, c, n, i, j) and flags the first/last MAC of each pixel.
// Optional LOOP_PERF_CNT_EN adds saturating stall_cycles / tuple_count performance counters.
module conv_loop_sequencer #(
    parameter int K        = 5,
    parameter int OUT_SIZE = 28,
    parameter int IN_CH    = 1,
    parameter int OUT_CH   = 6,
    parameter int N_STEP   = 4
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stall,
    output logic [7:0] m,
    output logic [7:0] r,
    output logic [7:0] c,
    output logic [7:0] n,
    output logic [3:0] i,
    output logic [3:0] j,
    output logic       iter_valid,
    output logic       acc_first,
    output logic       acc_last,
    output logic       busy,
    output logic       done
`ifdef LOOP_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] tuple_count
`endif
);

    // Base of the last input-channel group, i.e. the n value carried by acc_last.
    localparam int         N_LAST   = ((IN_CH - 1) / N_STEP) * N_STEP;
    localparam logic [7:0] N_LAST_W = 8'(N_LAST);
    localparam logic [7:0] N_STEP_W = 8'(N_STEP);
    localparam logic [3:0] K_LAST_W = 4'(K - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t     state_reg, state_next;
    logic [7:0] m_reg, m_next, r_reg, r_next, c_reg, c_next, n_reg, n_next;
    logic [3:0] i_reg, i_next, j_reg, j_next;
    logic       valid_reg, valid_next, first_reg, first_next, last_reg, last_next;
    logic       busy_reg, busy_next, done_reg, done_next;
    logic       j_wrap, i_wrap, n_wrap, c_wrap, r_wrap, m_wrap, last_tuple;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            m_reg     <= '0;
            r_reg     <= '0;
            c_reg     <= '0;
            n_reg     <= '0;
            i_reg     <= '0;
            j_reg     <= '0;
            valid_reg <= 1'b0;
            first_reg <= 1'b0;
            last_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            m_reg     <= m_next;
            r_reg     <= r_next;
            c_reg     <= c_next;
            n_reg     <= n_next;
            i_reg     <= i_next;
            j_reg     <= j_next;
            valid_reg <= valid_next;
            first_reg <= first_next;
            last_reg  <= last_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        m_next     = m_reg;
        r_next     = r_reg;
        c_next     = c_reg;
        n_next     = n_reg;
        i_next     = i_reg;
        j_next     = j_reg;
        valid_next = valid_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;

        // Terminal tests in int width so n + N_STEP cannot overflow before the compare.
        j_wrap     = int'(j_reg) >= K - 1;
        i_wrap     = int'(i_reg) >= K - 1;
        n_wrap     = int'(n_reg) + N_STEP >= IN_CH;
        c_wrap     = int'(c_reg) >= OUT_SIZE - 1;
        r_wrap     = int'(r_reg) >= OUT_SIZE - 1;
        m_wrap     = int'(m_reg) >= OUT_CH - 1;
        last_tuple = m_wrap && r_wrap && c_wrap && n_wrap && i_wrap && j_wrap;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                    m_next     = '0;
                    r_next     = '0;
                    c_next     = '0;
                    n_next     = '0;
                    i_next     = '0;
                    j_next     = '0;
                    valid_next = 1'b1;
                    busy_next  = 1'b1;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    if (last_tuple) begin
                        state_next = ST_DONE;
                        m_next     = '0;
                        r_next     = '0;
                        c_next     = '0;
                        n_next     = '0;
                        i_next     = '0;
                        j_next     = '0;
                        valid_next = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        j_next = j_wrap ? '0 : j_reg + 4'd1;
                        if (j_wrap) begin
                            i_next = i_wrap ? '0 : i_reg + 4'd1;
                            if (i_wrap) begin
                                n_next = n_wrap ? '0 : n_reg + N_STEP_W;
                                if (n_wrap) begin
                                    c_next = c_wrap ? '0 : c_reg + 8'd1;
                                    if (c_wrap) begin
                                        r_next = r_wrap ? '0 : r_reg + 8'd1;
                                        if (r_wrap) begin
                                            m_next = m_reg + 8'd1;
                                        end
                                    end
                                end
                            end
                        end
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
                valid_next = 1'b0;
            end
        endcase

        // Flags follow the next tuple; a held tuple re-decodes to the same values.
        first_next = valid_next && (n_next == 8'd0) && (i_next == 4'd0) && (j_next == 4'd0);
        last_next  = valid_next && (n_next == N_LAST_W) && (i_next == K_LAST_W) && (j_next == K_LAST_W);
    end

    assign m          = m_reg;
    assign r          = r_reg;
    assign c          = c_reg;
    assign n          = n_reg;
    assign i          = i_reg;
    assign j          = j_reg;
    assign iter_valid = valid_reg;
    assign acc_first  = first_reg;
    assign acc_last   = last_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

`ifdef LOOP_PERF_CNT_EN
    logic       perf_clear;
    logic [1:0] perf_inc;

    assign perf_clear  = (state_reg == ST_IDLE) && start;
    assign perf_inc[0] = (state_reg == ST_RUN) && stall;
    assign perf_inc[1] = (state_reg == ST_RUN) && !stall;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_perf
            logic [31:0] cnt_reg;
            always_ff @(posedge clock or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (perf_clear) begin
                    cnt_reg <= '0;
                end else if (perf_inc[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
        end
    endgenerate

    assign stall_cycles = g_perf[0].cnt_reg;
    assign tuple_count  = g_perf[1].cnt_reg;
`endif

endmodule

// File: tb/tb_conv_loop_sequencer.sv
// Scoreboard bench for conv_loop_sequencer: a small-parameter instance runs full jobs, a default instance covers stall/restart/reset.
module tb_conv_loop_sequencer;

    localparam logic [63:0] DONE_MARK = 64'h8000_0000_0000_0000;
    localparam logic [63:0] SENT      = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int tests_run    = 0;
    int tests_failed = 0;

    // Small instance: K=2, OUT_SIZE=2, IN_CH=8, OUT_CH=2, N_STEP=4 -> 64 tuples.
    logic       rst_n_s = 1'b0, start_s = 1'b0, stall_s = 1'b0;
    logic [7:0] m_s, r_s, c_s, n_s;
    logic [3:0] i_s, j_s;
    logic       iter_valid_s, acc_first_s, acc_last_s, busy_s, done_s;
    // Default instance.
    logic       rst_n_d = 1'b0, start_d = 1'b0, stall_d = 1'b0;
    logic [7:0] m_d, r_d, c_d, n_d;
    logic [3:0] i_d, j_d;
    logic       iter_valid_d, acc_first_d, acc_last_d, busy_d, done_d;
`ifdef LOOP_PERF_CNT_EN
    logic [31:0] stall_cycles_s, tuple_count_s, stall_cycles_d, tuple_count_d;
`endif

    conv_loop_sequencer #(.K(2), .OUT_SIZE(2), .IN_CH(8), .OUT_CH(2), .N_STEP(4)) u_small (
        .clock(clock), .rst_n(rst_n_s), .start(start_s), .stall(stall_s),
        .m(m_s), .r(r_s), .c(c_s), .n(n_s), .i(i_s), .j(j_s),
        .iter_valid(iter_valid_s), .acc_first(acc_first_s), .acc_last(acc_last_s),
        .busy(busy_s), .done(done_s)
`ifdef LOOP_PERF_CNT_EN
        , .stall_cycles(stall_cycles_s), .tuple_count(tuple_count_s)
`endif
    );

    conv_loop_sequencer u_dflt (
        .clock(clock), .rst_n(rst_n_d), .start(start_d), .stall(stall_d),
        .m(m_d), .r(r_d), .c(c_d), .n(n_d), .i(i_d), .j(j_d),
        .iter_valid(iter_valid_d), .acc_first(acc_first_d), .acc_last(acc_last_d),
        .busy(busy_d), .done(done_d)
`ifdef LOOP_PERF_CNT_EN
        , .stall_cycles(stall_cycles_d), .tuple_count(tuple_count_d)
`endif
    );

    wire [63:0] obs_s = {done_s, 21'b0, m_s, r_s, c_s, n_s, i_s, j_s, acc_first_s, acc_last_s};
    wire [63:0] obs_d = {done_d, 21'b0, m_d, r_d, c_d, n_d, i_d, j_d, acc_first_d, acc_last_d};
    wire [63:0] all_s = {19'b0, m_s, r_s, c_s, n_s, i_s, j_s, iter_valid_s, acc_first_s, acc_last_s, busy_s, done_s};
    wire [63:0] all_d = {19'b0, m_d, r_d, c_d, n_d, i_d, j_d, iter_valid_d, acc_first_d, acc_last_d, busy_d, done_d};

    logic [63:0] q_s[$];
    logic [63:0] q_d[$];
    logic [63:0] exp_s, exp_d;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference tuple for linear index idx, derived by index arithmetic rather than counters.
    function automatic logic [63:0] gen_tuple(input int idx, input int kk, input int os,
                                              input int ic, input int ns);
        int g, per, pix;
        logic [7:0] tm, tr, tc, tn;
        logic [3:0] ti, tj;
        logic f, l;
        g   = (ic + ns - 1) / ns;
        per = kk * kk * g;
        tj  = 4'(idx % kk);
        ti  = 4'((idx / kk) % kk);
        tn  = 8'(((idx / (kk * kk)) % g) * ns);
        pix = idx / per;
        tc  = 8'(pix % os);
        tr  = 8'((pix / os) % os);
        tm  = 8'(pix / (os * os));
        f   = (idx % per) == 0;
        l   = (idx % per) == per - 1;
        return {22'b0, tm, tr, tc, tn, ti, tj, f, l};
    endfunction

    always @(negedge clock) begin
        if (rst_n_s) begin
            if (iter_valid_s) begin
                exp_s = (q_s.size() > 0) ? q_s[0] : SENT;
                check("s_tuple", obs_s, exp_s);
                if (!stall_s && q_s.size() > 0 && !q_s[0][63]) void'(q_s.pop_front());
            end
            if (done_s) begin
                exp_s = (q_s.size() > 0) ? q_s[0] : SENT;
                check("s_done", obs_s, exp_s);
                if (q_s.size() > 0 && q_s[0][63]) void'(q_s.pop_front());
            end
        end
    end

    always @(negedge clock) begin
        if (rst_n_d) begin
            if (iter_valid_d) begin
                exp_d = (q_d.size() > 0) ? q_d[0] : SENT;
                check("d_tuple", obs_d, exp_d);
                if (!stall_d && q_d.size() > 0 && !q_d[0][63]) void'(q_d.pop_front());
            end
            if (done_d) begin
                exp_d = (q_d.size() > 0) ? q_d[0] : SENT;
                check("d_done", obs_d, exp_d);
                if (q_d.size() > 0 && q_d[0][63]) void'(q_d.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int  cnt, cyc, nstall, nf, nl;
        logic consumed, restarted;

        repeat (3) step();
        rst_n_s = 1'b1;
        rst_n_d = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("reset_idle_s", all_s, 64'd0);
            check("reset_idle_d", all_d, 64'd0);
        end

        // Small job with three stall cycles on tuple 5.
        for (int idx = 0; idx < 64; idx++) q_s.push_back(gen_tuple(idx, 2, 2, 8, 4));
        q_s.push_back(DONE_MARK);
        start_s = 1'b1;
        step();
        start_s = 1'b0;
        check("s_valid_after_start", 64'(iter_valid_s), 64'd1);
        check("s_busy_after_start", 64'(busy_s), 64'd1);
        cnt = 0; cyc = 0; nstall = 0; nf = 0; nl = 0;
        while (cnt < 64 && cyc < 300) begin
            stall_s = (cnt == 5) && (nstall < 3);
            if (stall_s) nstall++;
            consumed = iter_valid_s && !stall_s;
            if (consumed) begin
                nf += int'(acc_first_s);
                nl += int'(acc_last_s);
            end
            step();
            if (consumed) cnt++;
            cyc++;
        end
        stall_s = 1'b0;
        check("s_consumed", 64'(cnt), 64'd64);
        check("s_done_after_last", 64'(done_s), 64'd1);
        check("s_busy_in_done", 64'(busy_s), 64'd1);
        check("s_first_count", 64'(nf), 64'd8);
        check("s_last_count", 64'(nl), 64'd8);
        start_s = 1'b1;
        step();
        start_s = 1'b0;
        check("s_done_one_cycle", 64'(done_s), 64'd0);
        check("s_busy_dropped", 64'(busy_s), 64'd0);
        step();
        check("s_start_in_done_ignored", 64'({iter_valid_s, busy_s}), 64'd0);
        check("s_queue_drained", 64'(q_s.size()), 64'd0);
`ifdef LOOP_PERF_CNT_EN
        check("s_tuple_count", 64'(tuple_count_s), 64'd64);
        check("s_stall_cycles", 64'(stall_cycles_s), 64'd3);
        repeat (3) step();
        check("s_tuple_count_hold", 64'(tuple_count_s), 64'd64);
        check("s_stall_cycles_hold", 64'(stall_cycles_s), 64'd3);
`endif

        // Default instance: restart attempt at tuple 10, 5-cycle stall on tuple 13, reset at tuple 30.
        for (int idx = 0; idx <= 30; idx++) q_d.push_back(gen_tuple(idx, 5, 28, 1, 4));
        start_d = 1'b1;
        step();
        start_d = 1'b0;
        cnt = 0; cyc = 0; nstall = 0; restarted = 1'b0;
        while (cnt < 30 && cyc < 200) begin
            start_d = (cnt == 10) && !restarted;
            if (start_d) restarted = 1'b1;
            stall_d = (cnt == 13) && (nstall < 5);
            if (stall_d) nstall++;
            consumed = iter_valid_d && !stall_d;
            step();
            if (consumed) cnt++;
            cyc++;
        end
        start_d = 1'b0;
        stall_d = 1'b0;
        check("d_reached_tuple30", 64'(cnt), 64'd30);
        check("d_busy_mid_run", 64'(busy_d), 64'd1);
        @(negedge clock);
        #1;
        rst_n_d = 1'b0;
        #1;
        check("d_reset_async", all_d, 64'd0);
        check("d_queue_drained", 64'(q_d.size()), 64'd0);
        step();
        rst_n_d = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check("d_idle_after_reset", all_d, 64'd0);
        end

        // Restart after the abandoned run begins again from the origin.
        for (int idx = 0; idx <= 4; idx++) q_d.push_back(gen_tuple(idx, 5, 28, 1, 4));
        start_d = 1'b1;
        step();
        start_d = 1'b0;
        cnt = 0; cyc = 0;
        while (cnt < 4 && cyc < 50) begin
            consumed = iter_valid_d;
            step();
            if (consumed) cnt++;
            cyc++;
        end
        @(negedge clock);
        #1;
        check("d_restart_queue_drained", 64'(q_d.size()), 64'd0);
        rst_n_d = 1'b0;
        step();
        rst_n_d = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
